gbuf_sequencer: RTL and testbench

Instruction sequencer directly upstream of the global buffer. On a start pulse it latches four transfer counts and issues the fixed global-buffer instruction program: load weights, load activations, pointer reset, load outputs, pointer reset, read activations. Each instruction is issued one per cycle, and only when its data source is valid and the buffer is ready. It replaces hand-driven instruction streams from the host/testbench and gives the accelerator top level a single start/done handshake per layer.

---
 rtl/gbuf_sequencer_pkg.sv | 37 +++
 rtl/gbuf_sequencer.sv | 129 ++++++++++++
 tb/tb_gbuf_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gbuf_sequencer_pkg.sv
// Shared global-buffer instruction encodings and the sequencer's state type.
// Kept in package common so the buffer and the sequencer decode the same values.
package common;

    typedef enum logic [2:0] {
        I_NOP             = 3'd0,
        I_LOAD_WEIGHT     = 3'd1,
        I_LOAD_ACTIVATION = 3'd2,
        I_LOAD_OUTPUT     = 3'd3,
        I_POINTER_RESET   = 3'd4,
        I_READ_ACTIVATION = 3'd5
    } global_buffer_instruction_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD_W = 3'd1,
        LD_A = 3'd2,
        RST0 = 3'd3,
        LD_O = 3'd4,
        RST1 = 3'd5,
        RD_A = 3'd6,
        DONE = 3'd7
    } gbuf_seq_state_t;

    // Instruction a phase emits when its issue condition holds.
    function automatic global_buffer_instruction_t state_inst(input gbuf_seq_state_t s);
        case (s)
            LD_W:       return I_LOAD_WEIGHT;
            LD_A:       return I_LOAD_ACTIVATION;
            RST0, RST1: return I_POINTER_RESET;
            LD_O:       return I_LOAD_OUTPUT;
            RD_A:       return I_READ_ACTIVATION;
            default:    return I_NOP;
        endcase
    endfunction

endpackage

// File: rtl/gbuf_sequencer.sv
// Issues the fixed per-layer global-buffer program (W, A, RST, O, RST, R)
// behind a single start/done handshake.
module gbuf_sequencer
    import common::*;
#(
    parameter int cntWidth = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [cntWidth-1:0]        cfg_n_weight_i,
    input  logic [cntWidth-1:0]        cfg_n_act_i,
    input  logic [cntWidth-1:0]        cfg_n_out_i,
    input  logic [cntWidth-1:0]        cfg_n_read_i,
    input  logic                       ext_valid_i,
    input  logic                       obuf_valid_i,
    input  logic                       gbuf_ready_i,
    output global_buffer_instruction_t inst_o,
    output logic                       ext_pop_o,
    output logic                       obuf_pop_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [cntWidth-1:0]        remaining_o
);

    localparam logic [cntWidth-1:0] ONE = cntWidth'(1);

    gbuf_seq_state_t     state, state_d;
    logic [cntWidth-1:0] cnt, cnt_d;
    // The weight count goes straight into the counter at start, so only the
    // later phases need a latched copy.
    logic [cntWidth-1:0] n_act, n_out, n_read;
    logic                issue;

    always_comb begin
        issue = 1'b0;
        case (state)
            LD_W, LD_A:       issue = ext_valid_i && gbuf_ready_i;
            LD_O:             issue = obuf_valid_i && gbuf_ready_i;
            RST0, RST1, RD_A: issue = gbuf_ready_i;
            default:          issue = 1'b0;
        endcase
        if (abort_i) issue = 1'b0;
    end

    assign inst_o      = issue ? state_inst(state) : I_NOP;
    assign ext_pop_o   = issue && (state == LD_W || state == LD_A);
    assign obuf_pop_o  = issue && (state == LD_O);
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign remaining_o = cnt;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    if (cfg_n_weight_i != '0) begin
                        state_d = LD_W; cnt_d = cfg_n_weight_i;
                    end else if (cfg_n_act_i != '0) begin
                        state_d = LD_A; cnt_d = cfg_n_act_i;
                    end else begin
                        state_d = RST0; cnt_d = ONE;
                    end
                end
                DONE: begin
                    state_d = IDLE; cnt_d = '0;
                end
                default: if (issue) begin
                    if (cnt != ONE) begin
                        cnt_d = cnt - ONE;
                    end else begin
                        // Phase exit: skip empty load/read phases in zero cycles.
                        case (state)
                            LD_W: if (n_act != '0) begin
                                state_d = LD_A; cnt_d = n_act;
                            end else begin
                                state_d = RST0; cnt_d = ONE;
                            end
                            LD_A: begin
                                state_d = RST0; cnt_d = ONE;
                            end
                            RST0: if (n_out != '0) begin
                                state_d = LD_O; cnt_d = n_out;
                            end else begin
                                state_d = RST1; cnt_d = ONE;
                            end
                            LD_O: begin
                                state_d = RST1; cnt_d = ONE;
                            end
                            RST1: if (n_read != '0) begin
                                state_d = RD_A; cnt_d = n_read;
                            end else begin
                                state_d = DONE; cnt_d = '0;
                            end
                            default: begin
                                state_d = DONE; cnt_d = '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            cnt    <= '0;
            n_act  <= '0;
            n_out  <= '0;
            n_read <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == IDLE && start_i && !abort_i) begin
                n_act  <= cfg_n_act_i;
                n_out  <= cfg_n_out_i;
                n_read <= cfg_n_read_i;
            end
        end
    end

endmodule

// File: tb/tb_gbuf_sequencer.sv
// Directed bench for gbuf_sequencer: expected instruction stream is queued at
// start, and a negedge monitor checks every non-NOP instruction against it.
module tb_gbuf_sequencer;
    import common::*;

    typedef struct {
        global_buffer_instruction_t inst;
        logic ext;
        logic obuf;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    logic [15:0] cfg_w = '0, cfg_a = '0, cfg_o = '0, cfg_r = '0;
    logic ext_valid = 1'b1, obuf_valid = 1'b1, gbuf_ready = 1'b1;
    global_buffer_instruction_t inst;
    logic ext_pop, obuf_pop, busy, done;
    logic [15:0] remaining;

    exp_t exp_q[$];
    int total = 0, bad = 0;
    int ext_pops = 0, obuf_pops = 0;

    always #5 clk = ~clk;

    gbuf_sequencer #(.cntWidth(16)) dut (
        .clk(clk), .nrst(nrst), .start_i(start), .abort_i(abort),
        .cfg_n_weight_i(cfg_w), .cfg_n_act_i(cfg_a), .cfg_n_out_i(cfg_o), .cfg_n_read_i(cfg_r),
        .ext_valid_i(ext_valid), .obuf_valid_i(obuf_valid), .gbuf_ready_i(gbuf_ready),
        .inst_o(inst), .ext_pop_o(ext_pop), .obuf_pop_o(obuf_pop),
        .busy_o(busy), .done_o(done), .remaining_o(remaining)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every issued instruction must match the queue head and only
    // appear while the buffer is ready; NOP cycles must not pop anything.
    always @(negedge clk) begin
        if (nrst) begin
            if (ext_pop) ext_pops++;
            if (obuf_pop) obuf_pops++;
            total++;
            if (inst != I_NOP) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream: got inst %0d with nothing expected", inst);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (inst !== e.inst || ext_pop !== e.ext || obuf_pop !== e.obuf || !gbuf_ready) begin
                        bad++;
                        $display("FAIL stream: got inst=%0d ext=%0b obuf=%0b rdy=%0b expected inst=%0d ext=%0b obuf=%0b rdy=1",
                                 inst, ext_pop, obuf_pop, gbuf_ready, e.inst, e.ext, e.obuf);
                    end
                end
            end else if (ext_pop || obuf_pop) begin
                bad++;
                $display("FAIL nop_pop: got ext=%0b obuf=%0b expected 0 0", ext_pop, obuf_pop);
            end
        end
    end

    task automatic push(input global_buffer_instruction_t i, input logic e, input logic o, input int n);
        exp_t x;
        for (int j = 0; j < n; j++) begin
            x.inst = i; x.ext = e; x.obuf = o;
            exp_q.push_back(x);
        end
    endtask

    task automatic start_seq(input int m, input int n, input int o, input int p);
        cfg_w = 16'(m); cfg_a = 16'(n); cfg_o = 16'(o); cfg_r = 16'(p);
        push(I_LOAD_WEIGHT, 1'b1, 1'b0, m);
        push(I_LOAD_ACTIVATION, 1'b1, 1'b0, n);
        push(I_POINTER_RESET, 1'b0, 1'b0, 1);
        push(I_LOAD_OUTPUT, 1'b0, 1'b1, o);
        push(I_POINTER_RESET, 1'b0, 1'b0, 1);
        push(I_READ_ACTIVATION, 1'b0, 1'b0, p);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ext_pops = 0; obuf_pops = 0;
    endtask

    // Runs from cycle 1 after the start edge until done_o; mode selects the
    // per-cycle input pattern.
    task automatic run(input int mode, input int exp_done, input string name);
        int k;
        bit seen;
        seen = 1'b0;
        for (k = 1; k <= 200; k++) begin
            ext_valid  = !(mode == 1 && k >= 2 && k <= 4);
            gbuf_ready = (mode == 2) ? (k % 2 == 1) : 1'b1;
            if (mode == 3) begin
                start = (k == 4);
                if (k == 4) begin cfg_w = 1; cfg_a = 1; cfg_o = 1; cfg_r = 1; end
            end
            @(negedge clk);
            if (mode == 1 && k >= 2 && k <= 4) begin
                chk({name, "_stall_rem"}, int'(remaining), 2);
                chk({name, "_stall_inst"}, int'(inst), int'(I_NOP));
            end
            if (done) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!seen) begin
            bad++; total++;
            $display("FAIL %s_timeout: got no done in 200 cycles expected done at %0d", name, exp_done);
        end else begin
            chk({name, "_done_cycle"}, k, exp_done);
        end
        chk({name, "_queue_left"}, exp_q.size(), 0);
        @(posedge clk); #1;
        start = 1'b0; ext_valid = 1'b1; gbuf_ready = 1'b1;
        @(negedge clk);
        chk({name, "_done_pulse"}, int'(done), 0);
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic cycles(input int n);
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (j < n) begin @(posedge clk); #1; end
        end
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_inst"}, int'(inst), int'(I_NOP));
        chk({name, "_ext_pop"}, int'(ext_pop), 0);
        chk({name, "_obuf_pop"}, int'(obuf_pop), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_rem"}, int'(remaining), 0);
    endtask

    initial begin
        #1 chk_reset_outs("reset");
        #20 nrst = 1'b1;
        @(negedge clk);
        chk_reset_outs("post_reset");

        // Full program, all sources valid: 11 issues, done at 3+2+2+2+3.
        start_seq(3, 2, 2, 2);
        run(0, 12, "full");
        chk("full_ext_pops", ext_pops, 5);
        chk("full_obuf_pops", obuf_pops, 2);

        // ext_valid low in cycles 2..4 delays everything by 3 cycles.
        start_seq(3, 2, 2, 2);
        run(1, 15, "ext_stall");
        chk("stall_ext_pops", ext_pops, 5);

        // Only outputs: RST, O, RST, DONE.
        start_seq(0, 0, 1, 0);
        run(0, 4, "out_only");
        chk("out_only_ext_pops", ext_pops, 0);
        chk("out_only_obuf_pops", obuf_pops, 1);

        // Ready toggles 1/0 from cycle 1: RST(1) RST(3) R(5,7,9,11) DONE(12).
        start_seq(0, 0, 0, 4);
        run(2, 12, "rd_toggle");

        // Abort in LD_O after the first output.
        start_seq(1, 0, 2, 0);
        cycles(3);
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_inst", int'(inst), int'(I_NOP));
        chk("abort_done", int'(done), 0);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rem", int'(remaining), 0);
        chk("abort_left", exp_q.size(), 2);
        exp_q.delete();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        start_seq(1, 1, 1, 1);
        run(0, 7, "after_abort");

        // Start mid-sequence with different counts is ignored.
        start_seq(3, 2, 2, 2);
        run(3, 12, "restart_ignored");

        // Async reset mid-LD_A.
        start_seq(3, 2, 2, 2);
        cycles(4);
        chk("mid_rst_state_inst", int'(inst), int'(I_LOAD_ACTIVATION));
        #1 nrst = 1'b0;
        #1 chk_reset_outs("mid_rst");
        exp_q.delete();
        @(posedge clk); #1 nrst = 1'b1;
        @(negedge clk);
        chk("mid_rst_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
